// File: rtl/shift_sequencer_pkg.sv
// Shared types and helpers for the register-specified shift sequencer.
// Op encodings are common with the Val2 generator.
package shift_sequencer_pkg;

    localparam int SHIFT_CLAMP = 32;
    localparam int SH_DATA_W   = 32;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef struct packed {
        sh_op_e                 op;
        logic [SH_DATA_W-1:0]   operand;
        logic [7:0]             amount;
        logic                   carry;
    } sh_req_t;

    // Positions actually walked through the step shifter; ROR is modulo 32.
    function automatic logic [5:0] eff_count(input sh_op_e op, input logic [7:0] amount);
        if (op == SH_ROR)
            return {1'b0, amount[4:0]};
        else if (amount > 8'(SHIFT_CLAMP))
            return 6'(SHIFT_CLAMP);
        else
            return amount[5:0];
    endfunction

    // LSL/LSR beyond 32 clear both result and carry; ASR saturates to sign.
    function automatic logic over_flag(input sh_op_e op, input logic [7:0] amount);
        return ((op == SH_LSL) || (op == SH_LSR)) && (amount > 8'(SHIFT_CLAMP));
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational chunk of the sequenced shift: shifts by k (0..STEP)
// positions and reports the last bit shifted out.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KW     = 4
) (
    input  sh_op_e              i_op,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [KW-1:0]       i_k,
    input  logic                i_carry,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_carry
);

    logic [DATA_W:0]     w_lsl;
    logic [DATA_W:0]     w_lsr;
    logic [DATA_W:0]     w_asr;
    logic [2*DATA_W-1:0] w_ror;

    // One extra bit on the outgoing side captures the carry-out directly.
    assign w_lsl = {1'b0, i_data} << i_k;
    assign w_lsr = {i_data, 1'b0} >> i_k;
    assign w_asr = $signed({i_data, 1'b0}) >>> i_k;
    assign w_ror = {i_data, i_data} >> i_k;

    always_comb begin
        o_data  = i_data;
        o_carry = i_carry;
        if (i_k != '0) begin
            case (i_op)
                SH_LSL: begin
                    o_data  = w_lsl[DATA_W-1:0];
                    o_carry = w_lsl[DATA_W];
                end
                SH_LSR: begin
                    o_data  = w_lsr[DATA_W:1];
                    o_carry = w_lsr[0];
                end
                SH_ASR: begin
                    o_data  = w_asr[DATA_W:1];
                    o_carry = w_asr[0];
                end
                default: begin
                    o_data  = w_ror[DATA_W-1:0];
                    o_carry = w_ror[DATA_W-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle register-specified shift controller: walks the shift in
// chunks of at most STEP positions and returns result plus carry-out.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic [7:0]        amount_i,
    input  logic              carry_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    localparam int KW = $clog2(STEP + 1);

    state_e             r_state;
    state_e             w_next;
    sh_op_e             r_op;
    logic [DATA_W-1:0]  r_work;
    logic               r_wcarry;
    logic               r_over;
    logic [5:0]         r_rem;
    logic [DATA_W-1:0]  r_result;
    logic               r_carry;

    sh_req_t            w_req;
    logic               w_accept;
    logic [5:0]         w_eff;
    logic               w_over;
    logic [KW-1:0]      w_k;
    logic               w_last;
    logic [DATA_W-1:0]  w_step_data;
    logic               w_step_carry;

    assign w_req = '{op: sh_op_e'(op_i), operand: operand_i, amount: amount_i, carry: carry_i};

    assign w_accept = (r_state == ST_IDLE) && start_i && !flush_i;
    assign w_eff    = eff_count(w_req.op, w_req.amount);
    assign w_over   = over_flag(w_req.op, w_req.amount);
    assign w_k      = (r_rem < 6'(STEP)) ? KW'(r_rem) : KW'(STEP);
    assign w_last   = (r_rem <= 6'(STEP));

    shift_step #(
        .DATA_W (DATA_W),
        .KW     (KW)
    ) u_step (
        .i_op    (r_op),
        .i_data  (r_work),
        .i_k     (w_k),
        .i_carry (r_wcarry),
        .o_data  (w_step_data),
        .o_carry (w_step_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = (w_eff == 6'd0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (flush_i)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= SH_LSL;
            r_work   <= '0;
            r_wcarry <= 1'b0;
            r_over   <= 1'b0;
            r_rem    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else if (w_accept) begin
            r_op     <= w_req.op;
            r_work   <= w_req.operand;
            r_wcarry <= w_req.carry;
            r_over   <= w_over;
            r_rem    <= w_eff;
            // Zero effective count finishes at accept: either a true zero
            // amount or a ROR by a non-zero multiple of 32.
            if (w_eff == 6'd0) begin
                r_result <= w_req.operand;
                r_carry  <= (w_req.amount == 8'd0) ? w_req.carry : w_req.operand[DATA_W-1];
            end
        end else if ((r_state == ST_SHIFT) && !flush_i) begin
            r_work   <= w_step_data;
            r_wcarry <= w_step_carry;
            r_rem    <= r_rem - 6'(w_k);
            if (w_last) begin
                r_result <= r_over ? '0 : w_step_data;
                r_carry  <= r_over ? 1'b0 : w_step_carry;
            end
        end
    end

    assign ready_o  = (r_state == ST_IDLE) && rst;
    assign busy_o   = (r_state != ST_IDLE);
    assign done_o   = (r_state == ST_DONE) && !flush_i;
    assign result_o = r_result;
    assign carry_o  = r_carry;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed results and latencies.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] operand_i = 32'h0;
    logic [7:0]  amount_i = 8'h0;
    logic        carry_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        carry_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.DATA_W(32), .STEP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .operand_i (operand_i),
        .amount_i  (amount_i),
        .carry_i   (carry_i),
        .flush_i   (flush_i),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .carry_o   (carry_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Latency n = index of the negedge after the accept edge where done_o is seen.
    task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] opnd,
                          input logic [7:0] amt, input logic cin,
                          input logic [31:0] eres, input logic ecar, input int elat);
        int lat;
        lat = 0;
        @(negedge clk);
        for (int i = 0; i < 20 && ready_o !== 1'b1; i++) @(negedge clk);
        chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
        op_i = op; operand_i = opnd; amount_i = amt; carry_i = cin; start_i = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (done_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_res"}, result_o, eres);
        chk({tag, "_c"}, 32'(carry_o), 32'(ecar));
    endtask

    initial begin
        int dcnt;

        #2;
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_carry", 32'(carry_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ready_o), 32'd1);

        do_req("lsl1",     2'd0, 32'h8000_0001, 8'd1,    1'b0, 32'h0000_0002, 1'b1, 2);
        do_req("lsr32",    2'd1, 32'h8000_0000, 8'd32,   1'b0, 32'h0000_0000, 1'b1, 5);
        do_req("lsl40",    2'd0, 32'hFFFF_FFFF, 8'd40,   1'b1, 32'h0000_0000, 1'b0, 5);
        do_req("asr200",   2'd2, 32'h8000_0000, 8'd200,  1'b0, 32'hFFFF_FFFF, 1'b1, 5);
        do_req("ror32",    2'd3, 32'h1234_5678, 8'h20,   1'b1, 32'h1234_5678, 1'b0, 1);
        do_req("ror4",     2'd3, 32'h1234_5678, 8'd4,    1'b0, 32'h8123_4567, 1'b1, 2);
        do_req("amt0",     2'd1, 32'hDEAD_BEEF, 8'd0,    1'b1, 32'hDEAD_BEEF, 1'b1, 1);
        do_req("lsl12",    2'd0, 32'h0000_00FF, 8'd12,   1'b1, 32'h000F_F000, 1'b0, 3);
        do_req("lsr8",     2'd1, 32'h0000_0180, 8'd8,    1'b0, 32'h0000_0001, 1'b1, 2);
        do_req("asr31",    2'd2, 32'h4000_0000, 8'd31,   1'b0, 32'h0000_0000, 1'b1, 5);
        do_req("lsl32",    2'd0, 32'h0000_0001, 8'd32,   1'b0, 32'h0000_0000, 1'b1, 5);
        do_req("ror33",    2'd3, 32'h8000_0001, 8'h21,   1'b0, 32'hC000_0000, 1'b1, 2);

        // Flush during the second SHIFT cycle of LSL by 24.
        @(negedge clk);
        op_i = 2'd0; operand_i = 32'h0000_0001; amount_i = 8'd24; carry_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("fl_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        flush_i = 1'b1;
        chk("fl_done_sup", 32'(done_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        chk("fl_ready", 32'(ready_o), 32'd1);
        chk("fl_result", result_o, 32'hC000_0000);
        chk("fl_carry", 32'(carry_o), 32'd1);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) dcnt++;
        end
        chk("fl_nodone", 32'(dcnt), 32'd0);

        // Flush beats a simultaneous start.
        op_i = 2'd1; operand_i = 32'h0000_FFFF; amount_i = 8'd4; start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        chk("flst_busy", 32'(busy_o), 32'd0);
        chk("flst_ready", 32'(ready_o), 32'd1);

        // Reset while shifting.
        op_i = 2'd1; operand_i = 32'h8000_0000; amount_i = 8'd32; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_ready", 32'(ready_o), 32'd0);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_done", 32'(done_o), 32'd0);
        chk("mrst_result", result_o, 32'h0);
        chk("mrst_carry", 32'(carry_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) dcnt++;
        end
        chk("mrst_nodone", 32'(dcnt), 32'd0);

        // start_i held high: 3-cycle turnaround gives 4 completions in 12 cycles.
        op_i = 2'd0; operand_i = 32'h0000_0003; amount_i = 8'd8; carry_i = 1'b1; start_i = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) dcnt++;
        end
        start_i = 1'b0;
        chk("hold_dones", 32'(dcnt), 32'd4);
        chk("hold_result", result_o, 32'h0000_0300);
        chk("hold_carry", 32'(carry_o), 32'd0);

        // Back-to-back requests complete in order.
        do_req("b2b_a", 2'd1, 32'hF000_0000, 8'd4,  1'b0, 32'h0F00_0000, 1'b0, 2);
        do_req("b2b_b", 2'd2, 32'hF000_0000, 8'd16, 1'b0, 32'hFFFF_F000, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
